run_sequencer: RTL and testbench

//   Program run controller between the bench Start/Ack handshake and the core.

---
 rtl/run_sequencer.sv | 125 ++++++++++++
 tb/tb_run_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer
//   Program run controller sitting between the bench Start/Ack handshake and
//   the core. While Start is high the PC is held at its start address. After
//   Start falls, fetch/execute is enabled until the decoder reports a halt or
//   the watchdog expires. At that point the PC is frozen, Ack is raised, and
//   the cycle count and final PC are kept for the bench to read.
//
// Parameters
//   PC_W        program counter width
//   CNT_W       cycle counter width (must be able to hold MAX_CYCLES)
//   MAX_CYCLES  watchdog limit, counted in RUN cycles
//
// Ports
//   Clk       in   1      system clock, rising edge
//   Reset     in   1      asynchronous, active-low reset
//   Start     in   1      run request; PC held at START_ADDR while high
//   Halt      in   1      current instruction is halt (only used in RUN)
//   ProgCtr   in   PC_W   current PC from the program counter block
//   PcInit    out  1      program counter loads START_ADDR this cycle
//   PcEn      out  1      program counter advances this cycle
//   Ack       out  1      program finished (registered level)
//   Timeout   out  1      finish was caused by the watchdog (registered)
//   CycleCnt  out  CNT_W  RUN cycles executed, halt cycle included (registered)
//   LastPc    out  PC_W   ProgCtr captured at finish (registered)

module run_sequencer #(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic [PC_W-1:0]  ProgCtr,
  output logic             PcInit,
  output logic             PcEn,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [PC_W-1:0]  LastPc
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt_next;

  // The counter value that RUN will hold after this edge. The watchdog uses it
  // so the run ends on the cycle that reaches MAX_CYCLES, and the counter
  // never wraps.
  assign cnt_next = CycleCnt + CNT_W'(1);

  // The program counter controls come straight from the state and the inputs,
  // so the PC reacts in the same cycle. A halt instruction, or a restart
  // request, keeps the PC from moving past the current instruction.
  assign PcInit = (state == LOAD);
  assign PcEn   = (state == RUN) & ~Halt & ~Start;

  // Main sequencer. All status outputs are registered here.
  // In RUN, Start has priority over Halt, and Halt has priority over the
  // watchdog. A restart therefore discards a halt seen in the same cycle and
  // leaves the previous LastPc in place.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      Ack      <= 1'b0;
      Timeout  <= 1'b0;
      CycleCnt <= '0;
      LastPc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          CycleCnt <= '0;
          Timeout  <= 1'b0;
          Ack      <= 1'b0;
          if (!Start) begin
            state <= RUN;
          end
        end

        RUN: begin
          CycleCnt <= cnt_next;
          if (Start) begin
            state <= LOAD;
          end else if (Halt) begin
            state  <= DONE;
            LastPc <= ProgCtr;
            Ack    <= 1'b1;
          end else if (cnt_next == MAX_CNT) begin
            state   <= DONE;
            LastPc  <= ProgCtr;
            Ack     <= 1'b1;
            Timeout <= 1'b1;
          end
        end

        DONE: begin
          if (Start) begin
            state <= LOAD;
            Ack   <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//   Directed bench for run_sequencer. The watchdog limit is set to 16 so that
//   the timeout path can be exercised in a short run. A table of per-cycle
//   vectors covers a normal halted run, a restart from DONE, and a restart
//   that collides with a halt. Hand-written sequences cover reset, the
//   watchdog expiry, and an asynchronous reset in the middle of a run.

module tb_run_sequencer;

  localparam int PC_W       = 10;
  localparam int CNT_W      = 16;
  localparam int MAX_CYCLES = 16;
  localparam int NVEC       = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Halt;
  logic [PC_W-1:0]  ProgCtr;
  logic             PcInit;
  logic             PcEn;
  logic             Ack;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCnt;
  logic [PC_W-1:0]  LastPc;

  int compared   = 0;
  int mismatched = 0;

  // One record per clock cycle. The input fields are driven before the edge.
  // PcInit and PcEn are checked before the edge. The registered fields are
  // checked just after the edge.
  typedef struct {
    logic             start;
    logic             halt;
    logic [PC_W-1:0]  pc;
    logic             expPcInit;
    logic             expPcEn;
    logic             expAck;
    logic             expTimeout;
    logic [CNT_W-1:0] expCnt;
    logic [PC_W-1:0]  expLastPc;
  } vec_t;

  vec_t vecs [NVEC];

  run_sequencer #(
    .PC_W      (PC_W),
    .CNT_W     (CNT_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Halt    (Halt),
    .ProgCtr (ProgCtr),
    .PcInit  (PcInit),
    .PcEn    (PcEn),
    .Ack     (Ack),
    .Timeout (Timeout),
    .CycleCnt(CycleCnt),
    .LastPc  (LastPc)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Inputs change on the falling edge, well away from the active edge.
  task automatic applyStimulus(input logic s, input logic h, input logic [PC_W-1:0] pc);
    @(negedge Clk);
    Start   = s;
    Halt    = h;
    ProgCtr = pc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clockEdge();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Normal run: Start for one cycle, halt on the 5th RUN cycle at PC 4.
    vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 10'h000};
    vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'h000};
    vecs[2]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 10'h000};
    vecs[3]  = '{1'b0, 1'b0, 10'h001, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 10'h000};
    vecs[4]  = '{1'b0, 1'b0, 10'h002, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 10'h000};
    vecs[5]  = '{1'b0, 1'b0, 10'h003, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 10'h000};
    vecs[6]  = '{1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 10'h004};
    // A halt seen in DONE has no effect.
    vecs[7]  = '{1'b0, 1'b1, 10'h009, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 10'h004};
    // Restart from DONE with Start held for 3 cycles.
    vecs[8]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 10'h004};
    vecs[9]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'h004};
    vecs[10] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'h004};
    vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'h004};
    // Start and Halt in the same RUN cycle: restart wins.
    vecs[12] = '{1'b0, 1'b0, 10'h010, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 10'h004};
    vecs[13] = '{1'b0, 1'b0, 10'h011, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 10'h004};
    vecs[14] = '{1'b1, 1'b1, 10'h012, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 10'h004};
    vecs[15] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'h004};

    // Reset held low with Start high: everything stays at zero.
    Reset   = 1'b0;
    Start   = 1'b1;
    Halt    = 1'b0;
    ProgCtr = '0;
    repeat (3) clockEdge();
    checkOutput("reset Ack", 32'(Ack), 32'd0);
    checkOutput("reset Timeout", 32'(Timeout), 32'd0);
    checkOutput("reset PcInit", 32'(PcInit), 32'd0);
    checkOutput("reset PcEn", 32'(PcEn), 32'd0);
    checkOutput("reset CycleCnt", 32'(CycleCnt), 32'd0);
    checkOutput("reset LastPc", 32'(LastPc), 32'd0);

    applyStimulus(1'b0, 1'b0, '0);
    Reset = 1'b1;
    clockEdge();
    checkOutput("idle PcInit", 32'(PcInit), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].start, vecs[i].halt, vecs[i].pc);
      checkOutput($sformatf("vec%0d PcInit", i), 32'(PcInit), 32'(vecs[i].expPcInit));
      checkOutput($sformatf("vec%0d PcEn", i), 32'(PcEn), 32'(vecs[i].expPcEn));
      clockEdge();
      checkOutput($sformatf("vec%0d Ack", i), 32'(Ack), 32'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d Timeout", i), 32'(Timeout), 32'(vecs[i].expTimeout));
      checkOutput($sformatf("vec%0d CycleCnt", i), 32'(CycleCnt), 32'(vecs[i].expCnt));
      checkOutput($sformatf("vec%0d LastPc", i), 32'(LastPc), 32'(vecs[i].expLastPc));
    end

    // Watchdog: now in RUN with Halt held low. The 16th cycle ends the run.
    for (int i = 1; i <= MAX_CYCLES; i++) begin
      applyStimulus(1'b0, 1'b0, PC_W'(i + 32));
      checkOutput($sformatf("wd%0d PcEn", i), 32'(PcEn), 32'd1);
      clockEdge();
      checkOutput($sformatf("wd%0d Ack", i), 32'(Ack), (i == MAX_CYCLES) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wd%0d Timeout", i), 32'(Timeout), (i == MAX_CYCLES) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wd%0d CycleCnt", i), 32'(CycleCnt), 32'(i));
    end
    checkOutput("wd LastPc", 32'(LastPc), 32'd48);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wd done PcEn", 32'(PcEn), 32'd0);
    clockEdge();
    checkOutput("wd done Ack", 32'(Ack), 32'd1);
    checkOutput("wd done CycleCnt", 32'(CycleCnt), 32'd16);

    // Restart after a timeout. Ack drops at once; Timeout clears in LOAD.
    applyStimulus(1'b1, 1'b0, '0);
    clockEdge();
    checkOutput("rs Ack", 32'(Ack), 32'd0);
    checkOutput("rs Timeout held", 32'(Timeout), 32'd1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("rs PcInit", 32'(PcInit), 32'd1);
    clockEdge();
    checkOutput("rs Timeout", 32'(Timeout), 32'd0);
    checkOutput("rs CycleCnt", 32'(CycleCnt), 32'd0);

    // Seven RUN cycles, then an asynchronous reset between clock edges.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, PC_W'(i));
      clockEdge();
    end
    checkOutput("mid CycleCnt", 32'(CycleCnt), 32'd7);
    applyStimulus(1'b0, 1'b0, 10'h007);
    checkOutput("mid PcEn", 32'(PcEn), 32'd1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async PcEn", 32'(PcEn), 32'd0);
    checkOutput("async CycleCnt", 32'(CycleCnt), 32'd0);
    checkOutput("async LastPc", 32'(LastPc), 32'd0);
    checkOutput("async Ack", 32'(Ack), 32'd0);

    // Start is ignored while reset is low, and the design stays idle afterwards.
    applyStimulus(1'b1, 1'b0, '0);
    clockEdge();
    checkOutput("held PcInit", 32'(PcInit), 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    Reset = 1'b1;
    clockEdge();
    checkOutput("post PcInit", 32'(PcInit), 32'd0);
    checkOutput("post PcEn", 32'(PcEn), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    clockEdge();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("post load PcInit", 32'(PcInit), 32'd1);
    clockEdge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
